pulse_filter_delay: RTL

Multi-channel synthesizable model of specify-path transport with inertial pulse rejection, for cycle-based simulation and emulation of cells whose specify blocks use rise/fall path delays, `showcancelled` and `pulsestyle_ondetect`/`ondetect`. Each channel delays its input edges by a rise or fall latency in clock cycles. A pulse shorter than its leading-edge latency is cancelled, and cancellation can be flagged per channel. It sits between a stimulus/DUT model input bus and the consumer of the delayed outputs.

---
 rtl/pulse_filter_pkg.sv | 26 ++
 rtl/pulse_filter_delay_if.sv | 13 +
 rtl/pulse_chan.sv | 151 +++++++++++++++
 rtl/pulse_filter_delay.sv | 37 +++
 4 files changed

// File: rtl/pulse_filter_pkg.sv
// Shared types, counter width, delay range and load helper for the pulse filter.
// Used by every channel regardless of whether PULSE_SHOWCANCELLED_EN is defined.
package pulse_filter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        CANCEL = 2'd2
    } chan_state_t;

    localparam int CNT_W   = 4;
    localparam int DLY_MIN = 1;
    localparam int DLY_MAX = 15;

    // Clamp a delay into the counter range when it is loaded.
    function automatic logic [CNT_W-1:0] load_dly(input int d);
        if (d > DLY_MAX) begin
            return CNT_W'(DLY_MAX);
        end else if (d < DLY_MIN) begin
            return CNT_W'(DLY_MIN);
        end else begin
            return CNT_W'(d);
        end
    endfunction

endpackage

// File: rtl/pulse_filter_delay_if.sv
// Channel bus between the stimulus side (master) and the pulse filter (slave).
interface pulse_filter_delay_if #(
    parameter int N_CH = 2
) ();

    logic [N_CH-1:0] in;
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] err;

    modport master (output in, input out, input err);
    modport slave  (input in, output out, output err);

endinterface

// File: rtl/pulse_chan.sv
// One channel: rise/fall transport delay with inertial rejection of short pulses.
// With PULSE_SHOWCANCELLED_EN defined, cancelled pulses raise err over their window.
module pulse_chan
    import pulse_filter_pkg::*;
#(
    parameter int RISE_DLY = 2,
    parameter int FALL_DLY = 3,
    parameter bit ONDETECT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic err
);

    localparam logic [CNT_W-1:0] RISE_C = load_dly(RISE_DLY);
    localparam logic [CNT_W-1:0] FALL_C = load_dly(FALL_DLY);

    chan_state_t      state_r, state_s;
    logic             in_q_r;
    logic             tgt_r, tgt_s;
    logic             out_r, out_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             det_s;
    logic [CNT_W-1:0] dly_s;

`ifdef PULSE_SHOWCANCELLED_EN
    // sc/tc count edges remaining until the window start S and end T.
    logic [CNT_W-1:0] sc_r, sc_s;
    logic [CNT_W-1:0] tc_r, tc_s;
    logic             err_r, err_s;
`else
    logic             unused_ondetect_s;
    assign unused_ondetect_s = ONDETECT;
`endif

    // Next-state, schedule and cancel-window logic.
    always_comb begin
        det_s   = (in != in_q_r);
        dly_s   = in ? RISE_C : FALL_C;
        state_s = state_r;
        tgt_s   = tgt_r;
        cnt_s   = cnt_r;
        out_s   = out_r;
`ifdef PULSE_SHOWCANCELLED_EN
        sc_s    = sc_r;
        tc_s    = tc_r;
        err_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (det_s) begin
                    state_s = PEND;
                    tgt_s   = in;
                    cnt_s   = dly_s;
                end else begin
                    state_s = IDLE;
                end
            end
            PEND: begin
                if (cnt_r <= 4'd1) begin
                    // Expiry wins over a return edge landing on the same clock.
                    out_s = tgt_r;
                    if (det_s) begin
                        state_s = PEND;
                        tgt_s   = in;
                        cnt_s   = dly_s;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (det_s) begin
`ifdef PULSE_SHOWCANCELLED_EN
                    // dly_s is the trailing latency; cnt_r - 1 is edges left until L.
                    if (ONDETECT) begin
                        err_s   = 1'b1;
                        sc_s    = 4'd0;
                        tc_s    = dly_s - 4'd1;
                        state_s = CANCEL;
                    end else if ((cnt_r - 4'd1) >= dly_s) begin
                        state_s = IDLE;
                    end else begin
                        sc_s    = cnt_r - 4'd2;
                        tc_s    = dly_s - 4'd1;
                        state_s = CANCEL;
                    end
`else
                    state_s = IDLE;
`endif
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            CANCEL: begin
`ifdef PULSE_SHOWCANCELLED_EN
                if (det_s) begin
                    state_s = PEND;
                    tgt_s   = in;
                    cnt_s   = dly_s;
                end else if (tc_r == 4'd0) begin
                    state_s = IDLE;
                end else begin
                    err_s = (sc_r == 4'd0);
                    sc_s  = (sc_r == 4'd0) ? 4'd0 : (sc_r - 4'd1);
                    tc_s  = tc_r - 4'd1;
                end
`else
                state_s = IDLE;
`endif
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            in_q_r  <= 1'b0;
            tgt_r   <= 1'b0;
            out_r   <= 1'b0;
            cnt_r   <= 4'd0;
`ifdef PULSE_SHOWCANCELLED_EN
            sc_r    <= 4'd0;
            tc_r    <= 4'd0;
            err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            in_q_r  <= in;
            tgt_r   <= tgt_s;
            out_r   <= out_s;
            cnt_r   <= cnt_s;
`ifdef PULSE_SHOWCANCELLED_EN
            sc_r    <= sc_s;
            tc_r    <= tc_s;
            err_r   <= err_s;
`endif
        end
    end

    assign out = out_r;
`ifdef PULSE_SHOWCANCELLED_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/pulse_filter_delay.sv
// Multi-channel specify-path delay with inertial pulse rejection.
// Define PULSE_SHOWCANCELLED_EN to flag cancelled pulses on err.
module pulse_filter_delay
    import pulse_filter_pkg::*;
#(
    parameter int              N_CH          = 2,
    parameter int              RISE_DLY      = 2,
    parameter int              FALL_DLY      = 3,
    parameter logic [N_CH-1:0] ONDETECT_MASK = '0
) (
    input logic                 clk,
    input logic                 rst,
    pulse_filter_delay_if.slave bus
);

    if ((RISE_DLY < DLY_MIN) || (RISE_DLY > DLY_MAX)) begin : g_rise_range
        $error("pulse_filter_delay: RISE_DLY outside 1..15");
    end
    if ((FALL_DLY < DLY_MIN) || (FALL_DLY > DLY_MAX)) begin : g_fall_range
        $error("pulse_filter_delay: FALL_DLY outside 1..15");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_chan #(
            .RISE_DLY (RISE_DLY),
            .FALL_DLY (FALL_DLY),
            .ONDETECT (ONDETECT_MASK[i])
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .in  (bus.in[i]),
            .out (bus.out[i]),
            .err (bus.err[i])
        );
    end

endmodule
